// File: rtl/rr_arb_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_onehot
//  Description : Round-robin arbiter with valid/ready handshakes. Forwards the
//                winning requester's payload and presents a one-hot grant for
//                the downstream one-hot-to-binary encoder. The grant is held
//                stable while the downstream stalls.
//                Optional macro RR_ARB_ONEHOT_OUT_REG_EN inserts a one-entry
//                output register after the grant (1-cycle latency, full
//                throughput).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_onehot #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic                          oup_valid_o,
    input  logic                          oup_ready_i,
    output logic [DATA_WIDTH-1:0]         oup_data_o,
    output logic [NUM_REQ-1:0]            gnt_oh_o
);

    localparam int                 c_W2       = 2 * NUM_REQ;
    localparam logic [c_W2-1:0]    c_ONE      = c_W2'(1);
    localparam logic [NUM_REQ-1:0] c_PRIO_RST = NUM_REQ'(1);

    logic [NUM_REQ-1:0]    prio_q;
    logic [NUM_REQ-1:0]    prio_d;

    logic [c_W2-1:0]       w_dbl_req;
    logic [c_W2-1:0]       w_prio_ext;
    logic [c_W2-1:0]       w_mask;
    logic [c_W2-1:0]       w_masked;
    logic [c_W2-1:0]       w_first;
    logic [NUM_REQ-1:0]    w_arb_gnt;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [NUM_REQ-1:0]    w_rot;
    logic [DATA_WIDTH-1:0] w_mux_data;
    logic                  w_in_valid;

    // Round-robin search on a doubled request vector: the lower copy is masked
    // to bits at or above the priority pointer, the upper copy covers the
    // wrap-around, and the lowest surviving bit is the winner.
    assign w_dbl_req  = {req_valid_i, req_valid_i};
    assign w_prio_ext = {{NUM_REQ{1'b0}}, prio_q};
    assign w_mask     = ~(w_prio_ext - c_ONE);
    assign w_masked   = w_dbl_req & w_mask;
    assign w_first    = w_masked & (~w_masked + c_ONE);
    assign w_arb_gnt  = w_first[NUM_REQ-1:0] | w_first[c_W2-1:NUM_REQ];

    // AND-OR payload mux driven by the input-side grant
    always_comb begin
        w_mux_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_mux_data = w_mux_data | req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_in_valid = |(w_gnt & req_valid_i);

    // Next priority is the granted requester's left neighbour (with wrap)
    generate
        if (NUM_REQ == 1) begin : g_rot_single
            assign w_rot = w_gnt;
        end else begin : g_rot_multi
            assign w_rot = {w_gnt[NUM_REQ-2:0], w_gnt[NUM_REQ-1]};
        end
    endgenerate

`ifdef RR_ARB_ONEHOT_OUT_REG_EN

    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic [NUM_REQ-1:0]    out_gnt_q;
    logic [NUM_REQ-1:0]    out_gnt_d;
    logic                  w_load;

    // The register holds the beat stable, so no lock is needed here
    assign w_gnt  = w_arb_gnt;
    assign w_load = ~out_valid_q | oup_ready_i;

    // Fill the output register when empty or draining; advance the pointer on
    // the input-side handshake
    always_comb begin
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_gnt_d   = out_gnt_q;
        if (w_load) begin
            out_valid_d = w_in_valid;
            out_data_d  = w_mux_data;
            out_gnt_d   = w_gnt;
            if (w_in_valid) begin
                prio_d = w_rot;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q      <= c_PRIO_RST;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_gnt_q   <= '0;
        end else begin
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_gnt_q   <= out_gnt_d;
        end
    end

    assign req_ready_o = w_gnt & {NUM_REQ{w_load}};
    assign oup_valid_o = out_valid_q;
    assign oup_data_o  = out_data_q;
    assign gnt_oh_o    = out_gnt_q;

`else

    logic               lock_q;
    logic               lock_d;
    logic [NUM_REQ-1:0] lock_gnt_q;
    logic [NUM_REQ-1:0] lock_gnt_d;
    logic               w_hs;

    // A stalled beat keeps its grant so the encoded index cannot change
    assign w_gnt = lock_q ? lock_gnt_q : w_arb_gnt;
    assign w_hs  = w_in_valid & oup_ready_i;

    // Rotate priority on handshake; capture the lock on a stalled beat
    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_gnt_d = lock_gnt_q;
        if (w_hs) begin
            prio_d = w_rot;
            lock_d = 1'b0;
        end else if (w_in_valid) begin
            lock_d     = 1'b1;
            lock_gnt_d = w_gnt;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q     <= c_PRIO_RST;
            lock_q     <= 1'b0;
            lock_gnt_q <= '0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
        end
    end

    assign req_ready_o = w_gnt & {NUM_REQ{oup_ready_i}};
    assign oup_valid_o = w_in_valid;
    assign oup_data_o  = w_mux_data;
    assign gnt_oh_o    = w_gnt;

`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb_onehot
//  Description : Scoreboard bench for rr_arb_onehot. A driver applies directed
//                and random stimulus, runs an index-based reference model and
//                queues the expected outputs; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_onehot;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_data;
    logic              oup_valid;
    logic              oup_ready;
    logic [DW-1:0]     oup_data;
    logic [N-1:0]      gnt_oh;

    typedef struct {
        logic          v;
        logic [N-1:0]  g;
        logic [N-1:0]  r;
        logic [DW-1:0] d;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: priority index, lock, output register
    int            m_ptr    = 0;
    bit            m_locked = 1'b0;
    int            m_lidx   = 0;
    bit            m_rv     = 1'b0;
    logic [N-1:0]  m_rg     = '0;
    logic [DW-1:0] m_rd     = '0;

    rr_arb_onehot #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .oup_valid_o (oup_valid),
        .oup_ready_i (oup_ready),
        .oup_data_o  (oup_data),
        .gnt_oh_o    (gnt_oh)
    );

    always #5 clk = ~clk;

    function automatic int find_win(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // One cycle of stimulus plus the model's expected outputs for that cycle
    task automatic step(input bit r, input logic [N-1:0] v, input bit rdy, input bit rnd);
        exp_t          e;
        int            g;
        logic [DW-1:0] dsel;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        oup_ready = rdy;
        for (int k = 0; k < N; k++)
            req_data[k*DW +: DW] = rnd ? DW'($urandom) : DW'(k + 'hA0);
`ifdef RR_ARB_ONEHOT_OUT_REG_EN
        g    = find_win(v, m_ptr);
        dsel = (g >= 0) ? req_data[g*DW +: DW] : '0;
        e.v  = m_rv;
        e.g  = m_rg;
        e.d  = m_rd;
        e.r  = ((!m_rv || rdy) && g >= 0) ? N'(1 << g) : '0;
        q.push_back(e);
        if (r) begin
            m_ptr = 0; m_rv = 1'b0; m_rg = '0; m_rd = '0;
        end else if (!m_rv || rdy) begin
            m_rv = (g >= 0);
            m_rg = (g >= 0) ? N'(1 << g) : '0;
            m_rd = dsel;
            if (g >= 0) m_ptr = (g + 1) % N;
        end
`else
        g    = m_locked ? m_lidx : find_win(v, m_ptr);
        dsel = (g >= 0) ? req_data[g*DW +: DW] : '0;
        e.g  = (g >= 0) ? N'(1 << g) : '0;
        e.v  = (g >= 0) && v[g];
        e.d  = dsel;
        e.r  = rdy ? e.g : '0;
        q.push_back(e);
        if (r) begin
            m_ptr = 0; m_locked = 1'b0;
        end else if (e.v && rdy) begin
            m_ptr = (g + 1) % N; m_locked = 1'b0;
        end else if (e.v) begin
            m_locked = 1'b1; m_lidx = g;
        end
`endif
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (oup_valid !== e.v) begin
                    errors++;
                    $display("FAIL valid t=%0t got %b exp %b", $time, oup_valid, e.v);
                end
                checks++;
                if (gnt_oh !== e.g) begin
                    errors++;
                    $display("FAIL gnt t=%0t got %b exp %b", $time, gnt_oh, e.g);
                end
                checks++;
                if (req_ready !== e.r) begin
                    errors++;
                    $display("FAIL ready t=%0t got %b exp %b", $time, req_ready, e.r);
                end
                checks++;
                if (oup_data !== e.d) begin
                    errors++;
                    $display("FAIL data t=%0t got %h exp %h", $time, oup_data, e.d);
                end
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic
    initial begin
        rst       = 1'b1;
        req_valid = '0;
        oup_ready = 1'b0;
        req_data  = '0;

        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0000, 1, 0);
        // full load
        for (int i = 0; i < 8; i++) step(0, 4'b1111, 1, 0);
        // stall lock on requester 1
        step(0, 4'b1111, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 4'b1111, 0, 0);
        step(0, 4'b1111, 1, 0);
        step(0, 4'b1111, 1, 0);
        // wrap skip from pointer 3
        step(0, 4'b0011, 1, 0);
        step(0, 4'b0011, 1, 0);
        // reset mid-stall
        step(0, 4'b1111, 0, 0);
        step(1, 4'b1111, 0, 0);
        step(0, 4'b1111, 1, 0);
        step(0, 4'b0000, 1, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), N'($urandom), ($urandom_range(0, 9) < 7), 1);
        end
        step(0, 4'b0000, 1, 0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
